// File: rtl/ir_transmitter_if.sv
// Avalon-MM slave bus bundle for the NEC IR transmitter.
interface ir_transmitter_if;
  logic        avs_s1_cs_n;
  logic        avs_s1_address;
  logic        avs_s1_read;
  logic        avs_s1_write;
  logic [31:0] avs_s1_writedata;
  logic [31:0] avs_s1_readdata;
  logic        avs_s1_irq;

  modport master (
    output avs_s1_cs_n, avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
    input  avs_s1_readdata, avs_s1_irq
  );

  modport slave (
    input  avs_s1_cs_n, avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
    output avs_s1_readdata, avs_s1_irq
  );
endinterface

// File: rtl/ir_transmitter.sv
// NEC-protocol IR transmitter: a DATA write launches a 32-bit frame
// (lead mark/space, 32 LSB-first pulse-distance bits, stop mark) on a
// carrier-modulated LED output. CTRL/STATUS register for irq/done/overrun.
module ir_transmitter #(
  parameter int unsigned UNIT_CYCLES  = 28125,
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic             csi_clk,
  input  logic             csi_reset_n,
  ir_transmitter_if.slave  avs_s1,
  output logic             coe_ir_tx
);

  localparam int unsigned UCW = (UNIT_CYCLES  > 1) ? $clog2(UNIT_CYCLES)  : 1;
  localparam int unsigned CCW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LEAD_MARK  = 3'd1;
  localparam logic [2:0] LEAD_SPACE = 3'd2;
  localparam logic [2:0] BIT_MARK   = 3'd3;
  localparam logic [2:0] BIT_SPACE  = 3'd4;
  localparam logic [2:0] STOP_MARK  = 3'd5;

  logic [2:0]     state_q, state_d;
  logic [31:0]    frame_q, frame_d;
  logic [4:0]     bit_idx_q, bit_idx_d;
  logic [UCW-1:0] cyc_q, cyc_d;
  logic [4:0]     unit_q, unit_d;
  logic [CCW-1:0] car_q, car_d;
  logic           tx_q, tx_d;
  logic           done_q, done_d;
  logic           ovr_q, ovr_d;
  logic           irq_en_q, irq_en_d;

  logic       wr_data, wr_ctrl, rd;
  logic       busy, unit_end, state_end, entering, mark_d, done_set;
  logic [4:0] dur_units;

  assign wr_data  = ~avs_s1.avs_s1_cs_n & avs_s1.avs_s1_write & ~avs_s1.avs_s1_address;
  assign wr_ctrl  = ~avs_s1.avs_s1_cs_n & avs_s1.avs_s1_write &  avs_s1.avs_s1_address;
  assign rd       = ~avs_s1.avs_s1_cs_n & avs_s1.avs_s1_read;
  assign busy     = (state_q != IDLE);
  assign unit_end = (cyc_q == UCW'(UNIT_CYCLES - 1));

  // Length in units of the state currently being transmitted
  always_comb begin
    dur_units = 5'd1;
    case (state_q)
      LEAD_MARK:  dur_units = 5'd16;
      LEAD_SPACE: dur_units = 5'd8;
      BIT_SPACE:  dur_units = frame_q[bit_idx_q] ? 5'd3 : 5'd1;
      default:    dur_units = 5'd1;
    endcase
  end

  assign state_end = unit_end && (unit_q == dur_units - 5'd1);

  // Frame sequencing; a write while not IDLE (including the last STOP_MARK cycle) never starts a frame
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    done_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_data) begin
          state_d   = LEAD_MARK;
          frame_d   = avs_s1.avs_s1_writedata;
          bit_idx_d = '0;
        end
      end
      LEAD_MARK:  if (state_end) state_d = LEAD_SPACE;
      LEAD_SPACE: if (state_end) state_d = BIT_MARK;
      BIT_MARK:   if (state_end) state_d = BIT_SPACE;
      BIT_SPACE: begin
        if (state_end) begin
          bit_idx_d = bit_idx_q + 5'd1;
          state_d   = (bit_idx_q == 5'd31) ? STOP_MARK : BIT_MARK;
        end
      end
      STOP_MARK: begin
        if (state_end) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign entering = (state_d != state_q);
  assign mark_d   = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

  // Unit timing counters restart on every state entry
  always_comb begin
    cyc_d  = cyc_q;
    unit_d = unit_q;
    if (entering || !busy) begin
      cyc_d  = '0;
      unit_d = '0;
    end else if (unit_end) begin
      cyc_d  = '0;
      unit_d = unit_q + 5'd1;
    end else begin
      cyc_d  = cyc_q + UCW'(1);
    end
  end

  // Carrier generation; computed from the next state so the output register tracks state entry exactly
  always_comb begin
    car_d = car_q;
    tx_d  = tx_q;
    if (!mark_d) begin
      car_d = '0;
      tx_d  = 1'b0;
    end else if (entering) begin
      car_d = '0;
      tx_d  = 1'b1;
    end else if (car_q == CCW'(CARRIER_HALF - 1)) begin
      car_d = '0;
      tx_d  = ~tx_q;
    end else begin
      car_d = car_q + CCW'(1);
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins
  always_comb begin
    irq_en_d = wr_ctrl ? avs_s1.avs_s1_writedata[8] : irq_en_q;
    done_d   = (done_q & ~(wr_ctrl & avs_s1.avs_s1_writedata[1])) | done_set;
    ovr_d    = (ovr_q  & ~(wr_ctrl & avs_s1.avs_s1_writedata[2])) | (wr_data & busy);
  end

  // State and datapath registers
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_idx_q <= '0;
      cyc_q     <= '0;
      unit_q    <= '0;
      car_q     <= '0;
      tx_q      <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      cyc_q     <= cyc_d;
      unit_q    <= unit_d;
      car_q     <= car_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      irq_en_q  <= irq_en_d;
    end
  end

  // Zero-latency read mux; all sources are registers, so it reads 0 under reset
  always_comb begin
    avs_s1.avs_s1_readdata = '0;
    if (rd) begin
      if (avs_s1.avs_s1_address)
        avs_s1.avs_s1_readdata = {23'd0, irq_en_q, 5'd0, ovr_q, done_q, busy};
      else
        avs_s1.avs_s1_readdata = frame_q;
    end
  end

  assign avs_s1.avs_s1_irq = done_q & irq_en_q;
  assign coe_ir_tx         = tx_q;

endmodule

// File: tb/tb_ir_transmitter.sv
// Randomized self-checking bench for ir_transmitter with a segment-level
// waveform model (marks/spaces in units, carrier from cycle offset).
module tb_ir_transmitter;
  localparam int unsigned U  = 8;
  localparam int unsigned CH = 2;

  logic csi_clk = 1'b0;
  logic csi_reset_n;
  logic coe_ir_tx;

  ir_transmitter_if bus ();

  ir_transmitter #(.UNIT_CYCLES(U), .CARRIER_HALF(CH)) dut (
    .csi_clk     (csi_clk),
    .csi_reset_n (csi_reset_n),
    .avs_s1      (bus),
    .coe_ir_tx   (coe_ir_tx)
  );

  always #5 csi_clk = ~csi_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference register model
  bit done_m, ovr_m, irqen_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus_idle();
    bus.avs_s1_cs_n      = 1'b1;
    bus.avs_s1_address   = 1'b0;
    bus.avs_s1_read      = 1'b0;
    bus.avs_s1_write     = 1'b0;
    bus.avs_s1_writedata = '0;
  endtask

  task automatic bus_read(input logic addr, output logic [31:0] d);
    bus.avs_s1_cs_n    = 1'b0;
    bus.avs_s1_read    = 1'b1;
    bus.avs_s1_address = addr;
    #1;
    d = bus.avs_s1_readdata;
    bus_idle();
  endtask

  task automatic drive_write(input logic addr, input logic [31:0] d);
    bus.avs_s1_cs_n      = 1'b0;
    bus.avs_s1_write     = 1'b1;
    bus.avs_s1_address   = addr;
    bus.avs_s1_writedata = d;
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    return {23'd0, irqen_m, 5'd0, ovr_m, done_m, busy};
  endfunction

  task automatic apply_ctrl_model(input logic [31:0] d);
    irqen_m = d[8];
    if (d[1]) done_m = 1'b0;
    if (d[2]) ovr_m  = 1'b0;
  endtask

  task automatic check_status(input string tag, input bit busy);
    logic [31:0] d;
    bus_read(1'b1, d);
    check({tag, "_status"}, d, exp_status(busy));
    check({tag, "_irq"}, {31'd0, bus.avs_s1_irq}, {31'd0, done_m & irqen_m});
  endtask

  // Called 1 time unit after a rising edge; write lands on the next edge
  task automatic ctrl_write(input logic [31:0] d);
    drive_write(1'b1, d);
    @(posedge csi_clk); #1;
    bus_idle();
    apply_ctrl_model(d);
  endtask

  // Expected LED waveform, one entry per clock, from NEC segment rules
  task automatic add_seg(inout bit q[$], input bit mark, input int units);
    for (int c = 0; c < units * int'(U); c++)
      q.push_back(mark ? (((c / int'(CH)) % 2) == 0) : 1'b0);
  endtask

  // Launch frame w and follow it cycle by cycle. Optional bus op issued at
  // iteration op_at (negative = relative to frame length). abort_min >= 0
  // asserts reset at the first carrier-high cycle at or after that index.
  task automatic run_frame(input logic [31:0] w, input bit op_en, input int op_at_in,
                           input logic op_addr, input logic [31:0] op_data,
                           input int abort_min, output bit aborted);
    bit q[$];
    int n, op_at;
    logic [31:0] d;
    aborted = 1'b0;
    add_seg(q, 1'b1, 16);
    add_seg(q, 1'b0, 8);
    for (int i = 0; i < 32; i++) begin
      add_seg(q, 1'b1, 1);
      add_seg(q, 1'b0, w[i] ? 3 : 1);
    end
    add_seg(q, 1'b1, 1);
    n = q.size();
    op_at = (op_at_in < 0) ? n + op_at_in : op_at_in;

    drive_write(1'b0, w);
    @(posedge csi_clk); #1;
    bus_idle();

    for (int k = 0; k <= n; k++) begin
      check("tx", {31'd0, coe_ir_tx}, {31'd0, (k < n) ? q[k] : 1'b0});
      if (abort_min >= 0 && k >= abort_min && k < n && q[k]) begin
        csi_reset_n = 1'b0;
        #1;
        done_m = 0; ovr_m = 0; irqen_m = 0;
        check("abort_tx", {31'd0, coe_ir_tx}, 32'd0);
        check_status("abort", 1'b0);
        bus_read(1'b0, d);
        check("abort_data", d, 32'd0);
        aborted = 1'b1;
        return;
      end
      if (k == 0 || k == n - 1 || k == n || (op_en && k == op_at + 1))
        check_status($sformatf("frame_k%0d", k), k < n);
      if (k == n) break;
      if (op_en && k == op_at) drive_write(op_addr, op_data);
      @(posedge csi_clk); #1;
      if (op_en && k == op_at) begin
        bus_idle();
        if (op_addr) apply_ctrl_model(op_data);
        else ovr_m = 1'b1;
      end
      if (k + 1 == n) done_m = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] w;
    bit ab;
    bus_idle();
    done_m = 0; ovr_m = 0; irqen_m = 0;
    csi_reset_n = 1'b0;
    repeat (3) @(posedge csi_clk);
    #1;
    check("rst_tx", {31'd0, coe_ir_tx}, 32'd0);
    check_status("rst", 1'b0);
    bus_read(1'b0, d);
    check("rst_data", d, 32'd0);
    csi_reset_n = 1'b1;
    @(posedge csi_clk); #1;

    // directed lengths: all zeros, all ones, single low bit
    run_frame(32'h0000_0000, 1'b0, 0, 1'b0, '0, -1, ab);
    ctrl_write(32'h0000_0002);
    run_frame(32'hFFFF_FFFF, 1'b0, 0, 1'b0, '0, -1, ab);
    run_frame(32'h0000_0001, 1'b0, 0, 1'b0, '0, -1, ab);

    // overrun while busy, frame word must be unaffected
    ctrl_write(32'h0000_0006);
    run_frame(32'h1234_5678, 1'b1, 99, 1'b0, 32'hDEAD_BEEF, -1, ab);
    bus_read(1'b0, d);
    check("data_rb", d, 32'h1234_5678);

    // write in the very cycle STOP_MARK ends counts as overrun
    ctrl_write(32'h0000_0004);
    run_frame($urandom, 1'b1, -1, 1'b0, $urandom, -1, ab);
    check_status("after_late_wr", 1'b0);

    // done clear coinciding with done set leaves done set
    run_frame($urandom, 1'b1, -1, 1'b1, 32'h0000_0002, -1, ab);

    // irq enable, then clear done while keeping irq_en
    ctrl_write(32'h0000_0106);
    run_frame($urandom, 1'b0, 0, 1'b0, '0, -1, ab);
    check("irq_on", {31'd0, bus.avs_s1_irq}, 32'd1);
    ctrl_write(32'h0000_0102);
    check("irq_off", {31'd0, bus.avs_s1_irq}, 32'd0);
    check_status("irq_clr", 1'b0);

    // random frames with random mid-frame bus activity
    for (int r = 0; r < 4; r++) begin
      w = $urandom;
      run_frame(w, 1'b1, int'($urandom_range(40, 700)), 1'($urandom_range(0, 1)),
                $urandom, -1, ab);
      bus_read(1'b0, d);
      check("rand_data", d, w);
    end

    // reset mid-frame, held across clocks, then a full new frame
    run_frame(32'h0000_0000, 1'b0, 0, 1'b0, '0, 300, ab);
    check("aborted", {31'd0, ab}, 32'd1);
    repeat (3) @(posedge csi_clk);
    #1;
    check("rst_hold_tx", {31'd0, coe_ir_tx}, 32'd0);
    check_status("rst_hold", 1'b0);
    csi_reset_n = 1'b1;
    @(posedge csi_clk); #1;
    run_frame(32'hA5C3_0F96, 1'b0, 0, 1'b0, '0, -1, ab);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
